// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word and the memory-arbiter FSM state.
// Imported by mem_arbiter and mem_arb_streak.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        RESP
    } arb_state_t;

    localparam int unsigned STREAK_W = 8;

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating count of back-to-back data grants taken while a fetch waits.
// force_instr tells the arbiter to serve the fetch next.
module mem_arb_streak
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic force_instr
);

    localparam logic [STREAK_W-1:0] MaxCnt = STREAK_W'(MAX_DSTREAK);

    logic [STREAK_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {STREAK_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign force_instr = (count_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Define MEM_ARB_STARVE_GUARD_EN to bound data streaks that starve a waiting fetch.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    arb_state_t state_q, state_d;
    word_t      addr_q, addr_d;
    word_t      store_q, store_d;
    word_t      iload_q, iload_d;
    word_t      dload_q, dload_d;
    logic       ren_q, ren_d;
    logic       wen_q, wen_d;
    logic       ihit_q, ihit_d;
    logic       dhit_q, dhit_d;
    logic       d_req;
    logic       force_instr;
    logic       streak_inc;
    logic       streak_clr;

    assign d_req = dREN | dWEN;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_streak #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_streak (
        .CLK         (CLK),
        .nRST        (nRST),
        .inc         (streak_inc),
        .clr         (streak_clr),
        .force_instr (force_instr)
    );
`else
    logic unused_streak;
    assign unused_streak = ^{MAX_DSTREAK, streak_inc, streak_clr};
    assign force_instr   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        iload_d = iload_q;
        dload_d = dload_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !(force_instr && iREN)) begin
                    state_d = DACC;
                    addr_d  = daddr;
                    store_d = dstore;
                    wen_d   = dWEN;
                    ren_d   = ~dWEN;
                end else if (iREN) begin
                    state_d = IACC;
                    addr_d  = iaddr;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                end
            end
            IACC: begin
                if (ram_ready) begin
                    iload_d = ramload;
                    ihit_d  = 1'b1;
                    ren_d   = 1'b0;
                    state_d = RESP;
                end else if (!iREN) begin
                    ren_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            DACC: begin
                if (ram_ready) begin
                    // Only reads update dload; a write leaves the last read data intact.
                    if (ren_q) begin
                        dload_d = ramload;
                    end
                    dhit_d  = 1'b1;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    state_d = RESP;
                end else if (!d_req) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

    assign streak_inc = (state_q == IDLE) && (state_d == DACC) && iREN;
    assign streak_clr = (state_q == IDLE) && ((state_d == IACC) || !iREN);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule
